complex_fir_coeff_bank_loader: RTL and testbench
================================================

# complex_fir_coeff_bank_loader

Runtime-programmable successor to the fixed-table complex FIR coefficient setup block. Holds NUM_BANKS banks of LENGTH complex coefficients (signed Re/Im, DATA_WIDTH each), written through a simple write port. On command it streams one selected bank, in ascending or descending tap order, to the complex n-tap FIR over a valid/ready handshake. It then holds coeffSetFlag high until the next load.

## Interface
Parameters:
- LENGTH, 20, taps per bank; must be ≥ 2.
- DATA_WIDTH, 18, width of each of Re and Im, two's complement.
- NUM_BANKS, 4, number of coefficient banks; must be ≥ 1.

Derived widths: ADDR_W = max(1, clog2(LENGTH)); BANK_W = max(1, clog2(NUM_BANKS)).

Ports:
- clock  in  1  single clock; all state changes on its rising edge.
- resetN  in  1  asynchronous, active-low reset.
- wrEnable  in  1  write request, one coefficient per cycle.
- wrBank  in  BANK_W  target bank.
- wrAddress  in  ADDR_W  target tap.
- wrDataRe / wrDataIm  in  DATA_WIDTH each  coefficient value.
- wrReject  out  1  one-cycle pulse; the previous-cycle write was discarded.
- loadStart  in  1  request to stream a bank; ignored while busy.
- loadBank  in  BANK_W  bank to stream.
- loadReverse  in  1  0: tap 0 first, ascending; 1: tap LENGTH-1 first, descending.
- coeffValid  out  1  coefficient beat present.
- coeffReady  in  1  consumer accepts the beat.
- coeffOutRe / coeffOutIm  out  DATA_WIDTH each  coefficient of the current beat.
- coeffIndex  out  ADDR_W  tap index of the current beat.
- coeffLast  out  1  current beat is the final tap of the stream.
- coeffSetFlag  out  1  full bank delivered; held until the next accepted loadStart.
- busy  out  1  high in STREAM.

## Operation
- The FSM has three states: IDLE, STREAM, DONE.
- IDLE/DONE → STREAM on loadStart when loadBank < NUM_BANKS. This:
  - latches the bank and the direction;
  - sets index to 0 (ascending) or LENGTH-1 (descending);
  - loads the output register with that entry;
  - sets coeffValid, clears coeffSetFlag.
- loadStart with loadBank ≥ NUM_BANKS is ignored.
- STREAM, handshake (coeffValid & coeffReady) on a non-last beat:
  - index steps ±1;
  - the output register reloads from storage at the new index.
- STREAM, handshake on the last beat (index LENGTH-1 ascending, 0 descending):
  - state → DONE;
  - coeffValid=0, coeffSetFlag=1, outputs Re/Im/index cleared to 0.
- STREAM without handshake: all coeff* outputs hold stable.
- loadStart during STREAM is ignored.
- Writes are accepted when all of the following hold:
  - wrBank < NUM_BANKS and wrAddress < LENGTH;
  - the target bank is not the latched bank while in STREAM;
  - the target bank is not the loadBank of a loadStart accepted in the same cycle.
- A rejected write leaves storage unchanged and raises wrReject for exactly one cycle.
- Writes to other banks during STREAM proceed normally.
- Values pass through unchanged; no arithmetic, saturation or sign conversion. Full range −2^(DATA_WIDTH−1) … 2^(DATA_WIDTH−1)−1 is preserved.

## Timing
- Reset: state IDLE; all storage cleared to 0. All of the following are 0: coeffValid, coeffLast, coeffSetFlag, busy, wrReject, coeffOutRe, coeffOutIm, coeffIndex.
- Reset takes effect asynchronously, including mid-stream; the stream is abandoned and coeffSetFlag is not set.
- Load latency: with loadStart sampled at edge N, the first beat is valid in the cycle after edge N.
- With coeffReady held high, LENGTH beats occupy LENGTH consecutive cycles. coeffSetFlag rises at the edge of the final handshake.
- Restart: a loadStart in DONE may coincide with the falling of coeffValid. Back-to-back streams therefore have a minimum gap of one idle cycle.
- Writes: an accepted write at edge N is readable by any beat loaded at edge N+1 or later. wrReject is asserted in the cycle after the rejected request.
- Outputs are registered; there is no combinational path from coeffReady to coeffValid.

## Structure
- Shared package complex_coeff_pkg holds:
  - FSM state encodings (IDLE=2'd0, STREAM=2'd1, DONE=2'd2);
  - clog2-based width helpers for ADDR_W/BANK_W.
- Sub-module complex_coeff_bank_ram holds the NUM_BANKS×LENGTH×2×DATA_WIDTH storage. It has:
  - one synchronous write port;
  - one asynchronous read port addressed by {bank, index};
  - asynchronous clear on resetN.
- The top level owns the FSM, the write-accept logic and the output register.

## Test plan
- Reset, then write bank 0 with Re=100·k, Im=−k for k=0..19. Load bank 0 ascending with coeffReady=1. Required:
  - 20 consecutive beats with index 0..19 and exact values;
  - coeffLast only on index 19;
  - coeffSetFlag=1 from the final edge; busy=0.
- Write bank 1 with Re=−131072, Im=131071 at tap 0 and zeros elsewhere. Load bank 1 with loadReverse=1. Required: first beat index 19 (value 0), last beat index 0 = −131072+j131071, coeffLast on it.
- Load bank 0 with coeffReady alternating 1,0. Required: outputs stable while ready=0; stream completes in 39 cycles (20 handshakes); values identical to the first test.
- During a bank 2 stream, write bank 2 tap 5 = 777 and bank 3 tap 5 = 888. Required: wrReject pulses once for bank 2; a later bank 2 stream shows original tap 5; a bank 3 stream shows 888.
- Write wrAddress=20. Then issue loadStart with a write to loadBank in the same cycle. Required: wrReject for both; storage unchanged.
- Deassert resetN mid-stream at index 7. Required: all outputs 0 immediately; a subsequent load of any bank streams zeros and coeffSetFlag rises after 20 beats.

Source files
------------

// File: rtl/complex_coeff_pkg.sv
// Shared definitions for the complex FIR coefficient bank loader.
// Holds the loader FSM state encoding and the width helper used to size
// the tap-index and bank-select fields from LENGTH / NUM_BANKS.
package complex_coeff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Field width able to address n entries, never narrower than one bit.
    function automatic int width_for(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/complex_coeff_bank_ram.sv
// Purpose : NUM_BANKS x LENGTH storage of complex coefficients (Re/Im).
// Latency : write lands at the clock edge; read is combinational.
// Backpr. : none; the caller qualifies wr_en, out-of-range reads return 0.
// Ports   : clock, resetN (async clear of all entries), wr_en/wr_bank/
//           wr_addr/wr_re_dat/wr_im_dat (sync write), rd_bank/rd_addr ->
//           rd_re_dat/rd_im_dat (async read).
module complex_coeff_bank_ram #(
    parameter int LENGTH     = 20,
    parameter int DATA_WIDTH = 18,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_W     = 5,
    parameter int BANK_W     = 2
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  wr_en,
    input  logic [BANK_W-1:0]     wr_bank,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_re_dat,
    input  logic [DATA_WIDTH-1:0] wr_im_dat,
    input  logic [BANK_W-1:0]     rd_bank,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_re_dat,
    output logic [DATA_WIDTH-1:0] rd_im_dat
);

    logic [DATA_WIDTH-1:0] mem_re [NUM_BANKS][LENGTH];
    logic [DATA_WIDTH-1:0] mem_im [NUM_BANKS][LENGTH];

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                for (int t = 0; t < LENGTH; t++) begin
                    mem_re[b][t] <= '0;
                    mem_im[b][t] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_re[wr_bank][wr_addr] <= wr_re_dat;
            mem_im[wr_bank][wr_addr] <= wr_im_dat;
        end
    end

    // The loader presents speculative addresses (e.g. one past the last tap
    // on the final beat, or an unqualified loadBank); those read as zero.
    always_comb begin
        rd_re_dat = '0;
        rd_im_dat = '0;
        if (int'(rd_bank) < NUM_BANKS && int'(rd_addr) < LENGTH) begin
            rd_re_dat = mem_re[rd_bank][rd_addr];
            rd_im_dat = mem_im[rd_bank][rd_addr];
        end
    end

endmodule

// File: rtl/complex_fir_coeff_bank_loader.sv
// Purpose : runtime-programmable complex FIR coefficient banks, streamed on command.
// Latency : first beat valid the cycle after an accepted loadStart; 1 beat/cycle.
// Backpr. : coeffReady low holds every coeff* output; writes to a busy bank are rejected.
// Ports   : clock, resetN (async, active low); write port wrEnable/wrBank/
//           wrAddress/wrDataRe/wrDataIm -> wrReject; command loadStart/
//           loadBank/loadReverse; stream coeffValid/coeffReady/coeffOutRe/
//           coeffOutIm/coeffIndex/coeffLast; status coeffSetFlag, busy.
module complex_fir_coeff_bank_loader
    import complex_coeff_pkg::*;
#(
    parameter  int LENGTH     = 20,
    parameter  int DATA_WIDTH = 18,
    parameter  int NUM_BANKS  = 4,
    localparam int ADDR_W     = width_for(LENGTH),
    localparam int BANK_W     = width_for(NUM_BANKS)
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  wrEnable,
    input  logic [BANK_W-1:0]     wrBank,
    input  logic [ADDR_W-1:0]     wrAddress,
    input  logic [DATA_WIDTH-1:0] wrDataRe,
    input  logic [DATA_WIDTH-1:0] wrDataIm,
    output logic                  wrReject,
    input  logic                  loadStart,
    input  logic [BANK_W-1:0]     loadBank,
    input  logic                  loadReverse,
    output logic                  coeffValid,
    input  logic                  coeffReady,
    output logic [DATA_WIDTH-1:0] coeffOutRe,
    output logic [DATA_WIDTH-1:0] coeffOutIm,
    output logic [ADDR_W-1:0]     coeffIndex,
    output logic                  coeffLast,
    output logic                  coeffSetFlag,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(LENGTH - 1);

    state_t                state_q,    state_nxt;
    logic [BANK_W-1:0]     bank_q,     bank_nxt;
    logic                  rev_q,      rev_nxt;
    logic [ADDR_W-1:0]     idx_q,      idx_nxt;
    logic [DATA_WIDTH-1:0] re_q,       re_nxt;
    logic [DATA_WIDTH-1:0] im_q,       im_nxt;
    logic                  coeff_vld,  coeff_vld_nxt;
    logic                  last_q,     last_nxt;
    logic                  set_flag_q, set_flag_nxt;
    logic                  wr_reject_q;

    logic                  load_acc;
    logic                  beat_hs;
    logic [ADDR_W-1:0]     start_idx;
    logic [ADDR_W-1:0]     end_idx;
    logic [ADDR_W-1:0]     step_idx;
    logic [BANK_W-1:0]     rd_bank;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_WIDTH-1:0] rd_re_dat;
    logic [DATA_WIDTH-1:0] rd_im_dat;
    logic                  wr_in_range;
    logic                  wr_hits_stream;
    logic                  wr_hits_load;
    logic                  wr_acc;

    assign load_acc  = loadStart && (state_q != ST_STREAM) && (int'(loadBank) < NUM_BANKS);
    assign beat_hs   = coeff_vld && coeffReady;
    assign start_idx = loadReverse ? IDX_LAST : '0;
    assign end_idx   = rev_q ? '0 : IDX_LAST;
    assign step_idx  = rev_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);

    // One read port serves both the first beat (addressed from the command
    // inputs) and every later beat (the next index of the latched bank), so
    // the output register is always loaded straight from storage.
    assign rd_bank = (state_q == ST_STREAM) ? bank_q   : loadBank;
    assign rd_addr = (state_q == ST_STREAM) ? step_idx : start_idx;

    // A write may not touch the bank being streamed, nor the bank whose
    // stream starts this very cycle, so a stream always shows one snapshot.
    assign wr_in_range    = (int'(wrBank) < NUM_BANKS) && (int'(wrAddress) < LENGTH);
    assign wr_hits_stream = (state_q == ST_STREAM) && (wrBank == bank_q);
    assign wr_hits_load   = load_acc && (wrBank == loadBank);
    assign wr_acc         = wrEnable && wr_in_range && !wr_hits_stream && !wr_hits_load;

    complex_coeff_bank_ram #(
        .LENGTH     (LENGTH),
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_BANKS  (NUM_BANKS),
        .ADDR_W     (ADDR_W),
        .BANK_W     (BANK_W)
    ) u_bank_ram (
        .clock     (clock),
        .resetN    (resetN),
        .wr_en     (wr_acc),
        .wr_bank   (wrBank),
        .wr_addr   (wrAddress),
        .wr_re_dat (wrDataRe),
        .wr_im_dat (wrDataIm),
        .rd_bank   (rd_bank),
        .rd_addr   (rd_addr),
        .rd_re_dat (rd_re_dat),
        .rd_im_dat (rd_im_dat)
    );

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q    <= ST_IDLE;
            bank_q     <= '0;
            rev_q      <= 1'b0;
            idx_q      <= '0;
            re_q       <= '0;
            im_q       <= '0;
            coeff_vld  <= 1'b0;
            last_q     <= 1'b0;
            set_flag_q <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            bank_q     <= bank_nxt;
            rev_q      <= rev_nxt;
            idx_q      <= idx_nxt;
            re_q       <= re_nxt;
            im_q       <= im_nxt;
            coeff_vld  <= coeff_vld_nxt;
            last_q     <= last_nxt;
            set_flag_q <= set_flag_nxt;
        end
    end

    always_comb begin
        state_nxt     = state_q;
        bank_nxt      = bank_q;
        rev_nxt       = rev_q;
        idx_nxt       = idx_q;
        re_nxt        = re_q;
        im_nxt        = im_q;
        coeff_vld_nxt = coeff_vld;
        last_nxt      = last_q;
        set_flag_nxt  = set_flag_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_acc) begin
                    state_nxt     = ST_STREAM;
                    bank_nxt      = loadBank;
                    rev_nxt       = loadReverse;
                    idx_nxt       = start_idx;
                    re_nxt        = rd_re_dat;
                    im_nxt        = rd_im_dat;
                    coeff_vld_nxt = 1'b1;
                    // LENGTH >= 2, so the first beat is never the last one.
                    last_nxt      = 1'b0;
                    set_flag_nxt  = 1'b0;
                end
            end
            ST_STREAM: begin
                if (beat_hs) begin
                    if (idx_q == end_idx) begin
                        state_nxt     = ST_DONE;
                        idx_nxt       = '0;
                        re_nxt        = '0;
                        im_nxt        = '0;
                        coeff_vld_nxt = 1'b0;
                        last_nxt      = 1'b0;
                        set_flag_nxt  = 1'b1;
                    end else begin
                        idx_nxt  = step_idx;
                        re_nxt   = rd_re_dat;
                        im_nxt   = rd_im_dat;
                        last_nxt = (step_idx == end_idx);
                    end
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_reject_q <= 1'b0;
        end else begin
            wr_reject_q <= wrEnable && !wr_acc;
        end
    end

    assign wrReject     = wr_reject_q;
    assign coeffValid   = coeff_vld;
    assign coeffOutRe   = re_q;
    assign coeffOutIm   = im_q;
    assign coeffIndex   = idx_q;
    assign coeffLast    = last_q;
    assign coeffSetFlag = set_flag_q;
    assign busy         = (state_q == ST_STREAM);

endmodule

// File: tb/tb_complex_fir_coeff_bank_loader.sv
module tb_complex_fir_coeff_bank_loader;

    localparam int L  = 20;
    localparam int W  = 18;
    localparam int NB = 4;

    logic          clock = 1'b0;
    logic          resetN = 1'b1;
    logic          wrEnable = 1'b0;
    logic [1:0]    wrBank = '0;
    logic [4:0]    wrAddress = '0;
    logic [W-1:0]  wrDataRe = '0;
    logic [W-1:0]  wrDataIm = '0;
    logic          wrReject;
    logic          loadStart = 1'b0;
    logic [1:0]    loadBank = '0;
    logic          loadReverse = 1'b0;
    logic          coeffValid;
    logic          coeffReady = 1'b0;
    logic [W-1:0]  coeffOutRe;
    logic [W-1:0]  coeffOutIm;
    logic [4:0]    coeffIndex;
    logic          coeffLast;
    logic          coeffSetFlag;
    logic          busy;

    always #5 clock = ~clock;

    complex_fir_coeff_bank_loader #(
        .LENGTH(L), .DATA_WIDTH(W), .NUM_BANKS(NB)
    ) dut (
        .clock(clock), .resetN(resetN),
        .wrEnable(wrEnable), .wrBank(wrBank), .wrAddress(wrAddress),
        .wrDataRe(wrDataRe), .wrDataIm(wrDataIm), .wrReject(wrReject),
        .loadStart(loadStart), .loadBank(loadBank), .loadReverse(loadReverse),
        .coeffValid(coeffValid), .coeffReady(coeffReady),
        .coeffOutRe(coeffOutRe), .coeffOutIm(coeffOutIm),
        .coeffIndex(coeffIndex), .coeffLast(coeffLast),
        .coeffSetFlag(coeffSetFlag), .busy(busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain contents of every bank.
    logic [W-1:0] m_re [NB][L];
    logic [W-1:0] m_im [NB][L];

    // Expected beat sequence of one stream, derived from the model.
    logic [W-1:0] e_re [$];
    logic [W-1:0] e_im [$];
    int           e_idx [$];

    // Per-cycle capture of the stream interface, from first beat to final handshake.
    logic         c_vld [$];
    logic         c_rdy [$];
    logic [W-1:0] c_re [$];
    logic [W-1:0] c_im [$];
    logic [4:0]   c_idx [$];
    logic         c_last [$];
    logic         c_flag [$];
    bit           c_timeout;
    logic         post_flag, post_busy, post_vld, post_zero;

    task automatic model_clear;
        for (int b = 0; b < NB; b++)
            for (int t = 0; t < L; t++) begin
                m_re[b][t] = '0;
                m_im[b][t] = '0;
            end
    endtask

    task automatic build_expected(input int b, input bit rev);
        e_re.delete(); e_im.delete(); e_idx.delete();
        for (int k = 0; k < L; k++) begin
            int tap;
            tap = rev ? (L - 1 - k) : k;
            e_idx.push_back(tap);
            e_re.push_back(m_re[b][tap]);
            e_im.push_back(m_im[b][tap]);
        end
    endtask

    // One write request; on return wrReject for this request is visible.
    task automatic drive_write(input int b, input int a, input logic [W-1:0] re, input logic [W-1:0] im);
        wrEnable = 1'b1; wrBank = 2'(b); wrAddress = 5'(a);
        wrDataRe = re; wrDataIm = im;
        @(posedge clock); #1;
        wrEnable = 1'b0;
    endtask

    // Issues a load and records every cycle until the final handshake.
    // mode 0: ready always high, 1: ready alternating 1,0, 2: random ready.
    task automatic run_stream(input int b, input bit rev, input int mode);
        bit fin;
        c_vld.delete(); c_rdy.delete(); c_re.delete(); c_im.delete();
        c_idx.delete(); c_last.delete(); c_flag.delete();
        c_timeout = 1'b0;
        fin = 1'b0;
        loadStart = 1'b1; loadBank = 2'(b); loadReverse = rev; coeffReady = 1'b0;
        @(posedge clock); #1;
        loadStart = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic r;
            bit   endbeat;
            r = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            coeffReady = r;
            c_vld.push_back(coeffValid); c_rdy.push_back(r);
            c_re.push_back(coeffOutRe); c_im.push_back(coeffOutIm);
            c_idx.push_back(coeffIndex); c_last.push_back(coeffLast);
            c_flag.push_back(coeffSetFlag);
            endbeat = coeffValid && r && coeffLast;
            @(posedge clock); #1;
            if (endbeat) begin
                fin = 1'b1;
                break;
            end
        end
        coeffReady = 1'b0;
        c_timeout = !fin;
        post_flag = coeffSetFlag;
        post_busy = busy;
        post_vld  = coeffValid;
        post_zero = (coeffOutRe == '0) && (coeffOutIm == '0) && (coeffIndex == '0) && !coeffLast;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        #3;
        checks++; if (coeffValid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b need 0", coeffValid); end
        checks++; if (coeffLast !== 1'b0)    begin errors++; $display("FAIL reset_last got %b need 0", coeffLast); end
        checks++; if (coeffSetFlag !== 1'b0) begin errors++; $display("FAIL reset_flag got %b need 0", coeffSetFlag); end
        checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset_busy got %b need 0", busy); end
        checks++; if (wrReject !== 1'b0)     begin errors++; $display("FAIL reset_reject got %b need 0", wrReject); end
        checks++; if (coeffOutRe !== '0)     begin errors++; $display("FAIL reset_re got %0d need 0", coeffOutRe); end
        checks++; if (coeffOutIm !== '0)     begin errors++; $display("FAIL reset_im got %0d need 0", coeffOutIm); end
        checks++; if (coeffIndex !== '0)     begin errors++; $display("FAIL reset_index got %0d need 0", coeffIndex); end
        model_clear();
        #10 resetN = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_ascending;
        int k, nrej;
        nrej = 0;
        for (int t = 0; t < L; t++) begin
            drive_write(0, t, W'(100 * t), W'(-t));
            if (wrReject) nrej++;
            m_re[0][t] = W'(100 * t);
            m_im[0][t] = W'(-t);
        end
        checks++; if (nrej != 0) begin errors++; $display("FAIL asc_writes rejected %0d need 0", nrej); end
        run_stream(0, 1'b0, 0);
        build_expected(0, 1'b0);
        checks++; if (c_timeout || c_vld.size() != L) begin errors++; $display("FAIL asc_cycles got %0d need %0d", c_vld.size(), L); end
        k = 0;
        for (int i = 0; i < c_vld.size(); i++) begin
            checks++;
            if (!c_vld[i] || c_flag[i] || k >= L) begin
                errors++; $display("FAIL asc_valid cycle %0d vld=%b flag=%b need vld=1 flag=0", i, c_vld[i], c_flag[i]);
            end else if (c_idx[i] !== 5'(e_idx[k]) || c_re[i] !== e_re[k] || c_im[i] !== e_im[k] || c_last[i] !== (k == L - 1)) begin
                errors++;
                $display("FAIL asc_beat %0d got idx=%0d re=%0d im=%0d last=%b need idx=%0d re=%0d im=%0d last=%b",
                         k, c_idx[i], $signed(c_re[i]), $signed(c_im[i]), c_last[i], e_idx[k], $signed(e_re[k]), $signed(e_im[k]), k == L - 1);
            end
            k++;
        end
        checks++; if (post_flag !== 1'b1 || post_busy !== 1'b0 || post_vld !== 1'b0 || !post_zero) begin
            errors++; $display("FAIL asc_done got flag=%b busy=%b vld=%b zero=%b need 1 0 0 1", post_flag, post_busy, post_vld, post_zero);
        end
    endtask

    task automatic test_reverse;
        int k;
        for (int t = 0; t < L; t++) begin
            if (t == 0) begin
                drive_write(1, t, W'(-131072), W'(131071));
                m_re[1][t] = W'(-131072); m_im[1][t] = W'(131071);
            end else begin
                drive_write(1, t, '0, '0);
                m_re[1][t] = '0; m_im[1][t] = '0;
            end
        end
        run_stream(1, 1'b1, 0);
        build_expected(1, 1'b1);
        checks++; if (c_timeout || c_idx[0] !== 5'd19) begin errors++; $display("FAIL rev_first_idx got %0d need 19", c_idx[0]); end
        k = 0;
        for (int i = 0; i < c_vld.size(); i++) begin
            if (c_vld[i] && c_rdy[i]) begin
                checks++;
                if (k >= L) begin
                    errors++; $display("FAIL rev_count extra beat %0d", k);
                end else if (c_idx[i] !== 5'(e_idx[k]) || c_re[i] !== e_re[k] || c_im[i] !== e_im[k] || c_last[i] !== (k == L - 1)) begin
                    errors++;
                    $display("FAIL rev_beat %0d got idx=%0d re=%0d im=%0d last=%b need idx=%0d re=%0d im=%0d",
                             k, c_idx[i], $signed(c_re[i]), $signed(c_im[i]), c_last[i], e_idx[k], $signed(e_re[k]), $signed(e_im[k]));
                end
                k++;
            end
        end
        checks++; if (k != L || post_flag !== 1'b1) begin errors++; $display("FAIL rev_done got beats=%0d flag=%b need %0d 1", k, post_flag, L); end
    endtask

    task automatic test_backpressure;
        int k, unstable;
        run_stream(0, 1'b0, 1);
        build_expected(0, 1'b0);
        checks++; if (c_timeout || c_vld.size() != 2 * L - 1) begin errors++; $display("FAIL bp_cycles got %0d need %0d", c_vld.size(), 2 * L - 1); end
        unstable = 0;
        for (int i = 0; i + 1 < c_vld.size(); i++) begin
            if (c_vld[i] && !c_rdy[i]) begin
                if (c_vld[i+1] !== 1'b1 || c_re[i+1] !== c_re[i] || c_im[i+1] !== c_im[i] ||
                    c_idx[i+1] !== c_idx[i] || c_last[i+1] !== c_last[i]) unstable++;
            end
        end
        checks++; if (unstable != 0) begin errors++; $display("FAIL bp_stable got %0d changes need 0", unstable); end
        k = 0;
        for (int i = 0; i < c_vld.size(); i++) begin
            if (c_vld[i] && c_rdy[i]) begin
                checks++;
                if (k >= L) begin
                    errors++; $display("FAIL bp_count extra beat %0d", k);
                end else if (c_idx[i] !== 5'(e_idx[k]) || c_re[i] !== e_re[k] || c_im[i] !== e_im[k] || c_last[i] !== (k == L - 1)) begin
                    errors++;
                    $display("FAIL bp_beat %0d got idx=%0d re=%0d im=%0d need idx=%0d re=%0d im=%0d",
                             k, c_idx[i], $signed(c_re[i]), $signed(c_im[i]), e_idx[k], $signed(e_re[k]), $signed(e_im[k]));
                end
                k++;
            end
        end
        checks++; if (k != L || post_flag !== 1'b1) begin errors++; $display("FAIL bp_done got beats=%0d flag=%b need %0d 1", k, post_flag, L); end
    endtask

    task automatic test_write_during_stream;
        int nrej, rej_cyc, k;
        bit fin;
        nrej = 0;
        for (int b = 2; b < 4; b++)
            for (int t = 0; t < L; t++) begin
                logic [W-1:0] vr, vi;
                vr = W'($urandom); vi = W'($urandom);
                drive_write(b, t, vr, vi);
                if (wrReject) nrej++;
                m_re[b][t] = vr; m_im[b][t] = vi;
            end
        checks++; if (nrej != 0) begin errors++; $display("FAIL fill_writes rejected %0d need 0", nrej); end
        build_expected(2, 1'b0);
        nrej = 0; rej_cyc = -1; k = 0; fin = 1'b0;
        loadStart = 1'b1; loadBank = 2'd2; loadReverse = 1'b0; coeffReady = 1'b1;
        @(posedge clock); #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            bit endbeat;
            if (wrReject) begin nrej++; rej_cyc = cyc; end
            if (coeffValid) begin
                checks++;
                if (k >= L || c_idx.size() < 0) begin
                    errors++; $display("FAIL wds_count extra beat %0d", k);
                end else if (coeffIndex !== 5'(e_idx[k]) || coeffOutRe !== e_re[k] || coeffOutIm !== e_im[k]) begin
                    errors++;
                    $display("FAIL wds_beat %0d got idx=%0d re=%0d need idx=%0d re=%0d", k, coeffIndex, $signed(coeffOutRe), e_idx[k], $signed(e_re[k]));
                end
                k++;
            end
            endbeat = coeffValid && coeffLast;
            wrEnable  = (cyc == 3) || (cyc == 4);
            wrBank    = (cyc == 3) ? 2'd2 : 2'd3;
            wrAddress = 5'd5;
            wrDataRe  = (cyc == 3) ? W'(777) : W'(888);
            wrDataIm  = '0;
            loadStart = (cyc == 6);
            loadBank  = 2'd3;
            @(posedge clock); #1;
            if (endbeat) begin fin = 1'b1; break; end
        end
        wrEnable = 1'b0; loadStart = 1'b0; coeffReady = 1'b0;
        m_re[3][5] = W'(888); m_im[3][5] = '0;
        checks++; if (!fin || k != L) begin errors++; $display("FAIL wds_done got beats=%0d need %0d", k, L); end
        checks++; if (nrej != 1 || rej_cyc != 4) begin errors++; $display("FAIL wds_reject got count=%0d cycle=%0d need 1 4", nrej, rej_cyc); end

        for (int b = 2; b < 4; b++) begin
            bit rev;
            rev = 1'($urandom_range(0, 1));
            run_stream(b, rev, 2);
            build_expected(b, rev);
            k = 0;
            for (int i = 0; i < c_vld.size(); i++) begin
                if (c_vld[i] && c_rdy[i]) begin
                    checks++;
                    if (k >= L) begin
                        errors++; $display("FAIL after_wds_count bank %0d extra beat", b);
                    end else if (c_idx[i] !== 5'(e_idx[k]) || c_re[i] !== e_re[k] || c_im[i] !== e_im[k] || c_last[i] !== (k == L - 1)) begin
                        errors++;
                        $display("FAIL after_wds_beat bank %0d beat %0d got idx=%0d re=%0d need idx=%0d re=%0d",
                                 b, k, c_idx[i], $signed(c_re[i]), e_idx[k], $signed(e_re[k]));
                    end
                    k++;
                end
            end
            checks++; if (c_timeout || k != L) begin errors++; $display("FAIL after_wds_len bank %0d got %0d need %0d", b, k, L); end
        end
    endtask

    task automatic test_reject_cases;
        int k;
        bit done_seen;
        drive_write(0, 20, W'(5), W'(5));
        checks++; if (wrReject !== 1'b1) begin errors++; $display("FAIL rej_addr got %b need 1", wrReject); end
        @(posedge clock); #1;
        checks++; if (wrReject !== 1'b0) begin errors++; $display("FAIL rej_pulse_width got %b need 0", wrReject); end
        loadStart = 1'b1; loadBank = 2'd0; loadReverse = 1'b0; coeffReady = 1'b1;
        wrEnable = 1'b1; wrBank = 2'd0; wrAddress = 5'd3; wrDataRe = W'(555); wrDataIm = W'(555);
        @(posedge clock); #1;
        loadStart = 1'b0; wrEnable = 1'b0;
        checks++; if (wrReject !== 1'b1) begin errors++; $display("FAIL rej_same_cycle got %b need 1", wrReject); end
        done_seen = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (coeffSetFlag) begin done_seen = 1'b1; break; end
            @(posedge clock); #1;
        end
        coeffReady = 1'b0;
        checks++; if (!done_seen) begin errors++; $display("FAIL rej_stream_end got flag=%b need 1", coeffSetFlag); end
        run_stream(0, 1'b0, 0);
        build_expected(0, 1'b0);
        k = 0;
        for (int i = 0; i < c_vld.size(); i++) begin
            if (c_vld[i] && c_rdy[i]) begin
                checks++;
                if (k >= L) begin
                    errors++; $display("FAIL rej_count extra beat %0d", k);
                end else if (c_re[i] !== e_re[k] || c_im[i] !== e_im[k]) begin
                    errors++; $display("FAIL rej_storage tap %0d got re=%0d im=%0d need re=%0d im=%0d",
                                       e_idx[k], $signed(c_re[i]), $signed(c_im[i]), $signed(e_re[k]), $signed(e_im[k]));
                end
                k++;
            end
        end
    endtask

    task automatic test_reset_midstream;
        bit hit;
        int b, k;
        bit rev;
        hit = 1'b0;
        loadStart = 1'b1; loadBank = 2'd0; loadReverse = 1'b0; coeffReady = 1'b1;
        @(posedge clock); #1;
        loadStart = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (coeffValid && coeffIndex == 5'd7) begin hit = 1'b1; break; end
            @(posedge clock); #1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL mid_reach_idx7 got idx=%0d need 7", coeffIndex); end
        resetN = 1'b0;
        #1;
        checks++; if (coeffValid !== 1'b0 || busy !== 1'b0 || coeffLast !== 1'b0 || coeffSetFlag !== 1'b0) begin
            errors++; $display("FAIL mid_reset_ctrl got vld=%b busy=%b last=%b flag=%b need 0 0 0 0", coeffValid, busy, coeffLast, coeffSetFlag);
        end
        checks++; if (coeffOutRe !== '0 || coeffOutIm !== '0 || coeffIndex !== '0 || wrReject !== 1'b0) begin
            errors++; $display("FAIL mid_reset_data got re=%0d im=%0d idx=%0d rej=%b need 0", coeffOutRe, coeffOutIm, coeffIndex, wrReject);
        end
        model_clear();
        coeffReady = 1'b0;
        #2 resetN = 1'b1;
        @(posedge clock); #1;
        checks++; if (coeffSetFlag !== 1'b0) begin errors++; $display("FAIL mid_flag_after got %b need 0", coeffSetFlag); end
        b = $urandom_range(0, NB - 1);
        rev = 1'($urandom_range(0, 1));
        run_stream(b, rev, 2);
        k = 0;
        for (int i = 0; i < c_vld.size(); i++) begin
            if (c_vld[i] && c_rdy[i]) begin
                checks++;
                if (c_re[i] !== m_re[b][0] || c_im[i] !== m_im[b][0]) begin
                    errors++; $display("FAIL mid_zero beat %0d got re=%0d im=%0d need 0", k, c_re[i], c_im[i]);
                end
                k++;
            end
        end
        checks++; if (c_timeout || k != L || post_flag !== 1'b1) begin
            errors++; $display("FAIL mid_stream_done got beats=%0d flag=%b need %0d 1", k, post_flag, L);
        end
    endtask

    task automatic test_back_to_back;
        int nrej, k;
        nrej = 0;
        for (int n = 0; n < 24; n++) begin
            int b, t;
            logic [W-1:0] vr, vi;
            b = $urandom_range(0, NB - 1);
            t = $urandom_range(0, L - 1);
            vr = W'($urandom); vi = W'($urandom);
            drive_write(b, t, vr, vi);
            if (wrReject) nrej++;
            m_re[b][t] = vr; m_im[b][t] = vi;
        end
        checks++; if (nrej != 0) begin errors++; $display("FAIL b2b_writes rejected %0d need 0", nrej); end
        for (int s = 0; s < 4; s++) begin
            int b, mode;
            bit rev;
            b = $urandom_range(0, NB - 1);
            rev = 1'($urandom_range(0, 1));
            mode = $urandom_range(0, 2);
            run_stream(b, rev, mode);
            build_expected(b, rev);
            checks++; if (c_vld[0] !== 1'b1) begin errors++; $display("FAIL b2b_latency stream %0d got vld=%b need 1", s, c_vld[0]); end
            k = 0;
            for (int i = 0; i < c_vld.size(); i++) begin
                if (c_vld[i] && c_rdy[i]) begin
                    checks++;
                    if (k >= L) begin
                        errors++; $display("FAIL b2b_count stream %0d extra beat", s);
                    end else if (c_idx[i] !== 5'(e_idx[k]) || c_re[i] !== e_re[k] || c_im[i] !== e_im[k] || c_last[i] !== (k == L - 1)) begin
                        errors++;
                        $display("FAIL b2b_beat stream %0d beat %0d got idx=%0d re=%0d im=%0d need idx=%0d re=%0d im=%0d",
                                 s, k, c_idx[i], $signed(c_re[i]), $signed(c_im[i]), e_idx[k], $signed(e_re[k]), $signed(e_im[k]));
                    end
                    k++;
                end
            end
            checks++; if (c_timeout || k != L || post_flag !== 1'b1 || post_vld !== 1'b0) begin
                errors++; $display("FAIL b2b_done stream %0d got beats=%0d flag=%b vld=%b need %0d 1 0", s, k, post_flag, post_vld, L);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        test_reset();
        test_ascending();
        test_reverse();
        test_backpressure();
        test_write_during_stream();
        test_reject_cases();
        test_reset_midstream();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
